waveguide_tx_client: RTL and testbench
======================================

# waveguide_tx_client

Per-router requester for the shared optical waveguide, the counterpart of the fixed-priority waveguide arbiter. It buffers locally generated flits, raises `request` once a complete packet is queued, and accepts a one-cycle `grant`. It then streams the packet onto the waveguide at one flit per cycle and pulses `done` to release the arbiter. One instance sits in each router and drives one bit of the arbiter's `request`/`done` vectors and receives one bit of `grant`.

## Interface
- `DATA_WIDTH`, 32, flit payload width in bits.
- `FIFO_DEPTH`, 16, flit buffer depth. Must be a power of two, ≥2. Every packet must be ≤ `FIFO_DEPTH` flits.
- `clk`  input  1  clock; all logic on rising edge.
- `rst_n`  input  1  synchronous active-low reset.
- `in_valid`  input  1  local flit offered.
- `in_ready`  output  1  buffer can accept a flit; `in_ready = (fifo_count < FIFO_DEPTH)`.
- `in_data`  input  `DATA_WIDTH`  flit payload.
- `in_last`  input  1  flit is the final flit of its packet.
- `request`  output  1  to arbiter `request[i]`.
- `grant`  input  1  from arbiter `grant[i]`.
- `done`  output  1  to arbiter `done[i]`; one-cycle pulse.
- `tx_valid`  output  1  flit on waveguide this cycle. The link has no backpressure.
- `tx_data`  output  `DATA_WIDTH`  waveguide payload.
- `tx_last`  output  1  final flit of the transmitted packet.
- `spurious_grant`  output  1  sticky flag: `grant` was seen high outside REQ.

## Operation
- FIFO stores `{last, data}`. A push occurs when `in_valid & in_ready`; a pop occurs when `tx_valid`.
- `pkt_count` counts complete packets in the FIFO:
  - +1 on a push with `in_last`.
  - −1 on a pop with `tx_last`.
  - Both in the same cycle: no change.
- FSM states, with outputs decoded from the registered state:
  - IDLE: all handshake outputs 0. Go to REQ when `pkt_count != 0`.
  - REQ: `request=1`. When `grant==1` is sampled, go to XMIT. Otherwise stay in REQ, holding `request` indefinitely.
  - XMIT: `tx_valid=1`, with `tx_data`/`tx_last` taken from the FIFO head. Pops one flit per cycle. On the cycle where `tx_last=1`, go to DONE.
  - DONE: `done=1` for exactly one cycle, then go to IDLE.
- Only the head packet is transmitted per grant. Remaining packets require a fresh request/grant cycle.
- Pushes continue during all states. Simultaneous push and pop is legal.
- `grant` sampled high in IDLE, XMIT or DONE is ignored for control and sets `spurious_grant`. The flag clears only on reset.

## Timing
- Reset (`rst_n==0` at an edge): FIFO empty, `pkt_count=0`, state IDLE. Every output is 0 in the following cycle, except `in_ready`, which is 1.
- Reset mid-packet discards all buffered and in-flight flits, and no `done` is issued. The system must reset the arbiter in the same cycle.
- Latency:
  - Push with `in_last` at edge E0 gives `request=1` after E1.
  - `grant` sampled at edge Eg gives the first `tx_valid` after Eg. `request` falls in that same cycle, matching the arbiter clearing its grant on the same edge.
  - A packet of N flits occupies N consecutive `tx_valid` cycles.
  - `done` is high in the cycle after `tx_last`.
  - Earliest re-request is 2 cycles after `done`: DONE→IDLE, then IDLE→REQ.
- `request` and `tx_valid` are never high in the same cycle. `done` is never high together with `request` or `tx_valid`.
- Full FIFO: `in_ready=0`. It rises in the cycle after a pop frees an entry.

## Configuration
- `TX_CLIENT_STATS_EN` defined: adds the following outputs, both cleared by reset.
  - `pkts_sent[15:0]`: increments on each `done`, saturates at 0xFFFF.
  - `grant_wait_max[15:0]`: largest number of cycles spent in REQ for any packet, saturating.
- `TX_CLIENT_STATS_EN` undefined: these ports and their logic are absent. Functional behaviour is otherwise identical.

## Test plan
- Reset, then push a 3-flit packet A0..A2 with `grant` tied 0 → `request=1` from the 2nd cycle after the A2 push and held; `tx_valid` stays 0.
- Same setup, then pulse `grant` for 1 cycle → next 3 cycles `tx_data`=A0,A1,A2 with `tx_last` on A2; `request` is 0 from the first flit; `done`=1 one cycle after A2, then 0.
- Queue 2-flit packet B and 1-flit packet C, grant twice → B transmitted, `done`, IDLE, REQ 2 cycles after `done`, second grant → C transmitted; `pkt_count` ends at 0.
- Push 16 single-flit packets with no grant → `in_ready=0`. Grant once → one flit sent, and `in_ready` returns to 1 the following cycle.
- Assert `grant` while IDLE → no `tx_valid`, `spurious_grant=1` and sticky. Assert `rst_n=0` mid-XMIT → all outputs 0 the next cycle, FIFO empty.
- With `TX_CLIENT_STATS_EN`: hold REQ for 7 cycles before the grant, send 2 packets → `pkts_sent=2`, `grant_wait_max=7`.

Source files
------------

// File: rtl/waveguide_tx_client.sv
// Per-router waveguide requester: buffers flits, requests once a full packet is queued, streams it on grant.
// Optional statistics outputs are enabled with TX_CLIENT_STATS_EN.
module waveguide_tx_client #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  request,
    input  logic                  grant,
    output logic                  done,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_last,
    output logic                  spurious_grant
`ifdef TX_CLIENT_STATS_EN
    ,
    output logic [15:0]           pkts_sent,
    output logic [15:0]           grant_wait_max
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_XMIT, S_DONE} state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         count;
    logic [AW:0]         pkt_count;
    logic [DATA_WIDTH:0] head;
    logic                push, pop, pkt_in, pkt_out;

    assign head     = mem[rd_ptr];
    assign in_ready = (count != FULL);
    assign push     = in_valid & in_ready;
    assign pop      = tx_valid;
    assign pkt_in   = push & in_last;
    assign pkt_out  = pop & head[DATA_WIDTH];

    // Storage is left unreset; only pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {in_last, in_data};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pkt_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            case ({pkt_in, pkt_out})
                2'b10:   pkt_count <= pkt_count + 1'b1;
                2'b01:   pkt_count <= pkt_count - 1'b1;
                default: pkt_count <= pkt_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            spurious_grant <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant && state != S_REQ)
                spurious_grant <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        request   = 1'b0;
        tx_valid  = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: if (pkt_count != '0) state_nxt = S_REQ;
            S_REQ: begin
                request = 1'b1;
                if (grant) state_nxt = S_XMIT;
            end
            S_XMIT: begin
                tx_valid = 1'b1;
                if (head[DATA_WIDTH]) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Payload is forced to zero outside XMIT so the link sees no stale data.
    assign tx_data = tx_valid ? head[DATA_WIDTH-1:0] : '0;
    assign tx_last = tx_valid & head[DATA_WIDTH];

`ifdef TX_CLIENT_STATS_EN
    logic [15:0] wait_cnt, wait_inc;

    // The grant cycle itself counts as a cycle spent waiting in REQ.
    assign wait_inc = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkts_sent      <= '0;
            grant_wait_max <= '0;
            wait_cnt       <= '0;
        end else begin
            if (done && pkts_sent != 16'hFFFF)
                pkts_sent <= pkts_sent + 16'd1;
            if (state == S_REQ) begin
                wait_cnt <= wait_inc;
                if (grant && wait_inc > grant_wait_max)
                    grant_wait_max <= wait_inc;
            end else begin
                wait_cnt <= '0;
            end
        end
    end
`endif
endmodule

// File: tb/tb_waveguide_tx_client.sv
// Scoreboard bench for waveguide_tx_client: flits are queued as driven and matched as they leave on the link.
module tb_waveguide_tx_client;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          request;
    logic          grant = 1'b0;
    logic          done;
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_last;
    logic          spurious_grant;
`ifdef TX_CLIENT_STATS_EN
    logic [15:0]   pkts_sent, grant_wait_max;
`endif

    int n_chk = 0;
    int n_err = 0;
    logic [63:0] sb_q[$];

    waveguide_tx_client #(.DATA_WIDTH(DW), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .request(request), .grant(grant), .done(done),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last),
        .spurious_grant(spurious_grant)
`ifdef TX_CLIENT_STATS_EN
        , .pkts_sent(pkts_sent), .grant_wait_max(grant_wait_max)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        grant    = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Offer one flit for one edge; only an accepted flit is expected on the link.
    task automatic push_flit(input logic [DW-1:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        if (in_ready)
            sb_q.push_back(64'({l, d}));
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!request && n < 40) begin
            step();
            n++;
        end
        chk(tag, 64'(request), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 40) begin
            step();
            n++;
        end
        chk(tag, 64'(done), 64'd1);
    endtask

    task automatic pulse_grant();
        grant = 1'b1;
        step();
        grant = 1'b0;
    endtask

    task automatic send_pkt(input string tag);
        wait_req(tag);
        pulse_grant();
        wait_done(tag);
    endtask

    // Link monitor: every flit must match the head of the scoreboard; handshakes stay exclusive.
    always @(negedge clk) begin
        logic [63:0] exp;
        if (tx_valid) begin
            if (sb_q.size() == 0) begin
                chk("tx_unexpected", 64'({tx_last, tx_data}), 64'hDEAD);
            end else begin
                exp = sb_q.pop_front();
                chk("tx_flit", 64'({tx_last, tx_data}), exp);
            end
        end
        chk("excl_req_tx", 64'(request & tx_valid), 64'd0);
        chk("excl_done", 64'(done & (request | tx_valid)), 64'd0);
    end

    initial begin
        do_reset();
        chk("rst_request", 64'(request), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_tx_data", 64'(tx_data), 64'd0);
        chk("rst_tx_last", 64'(tx_last), 64'd0);
        chk("rst_spurious", 64'(spurious_grant), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Packet A: request latency and hold without grant
        for (int i = 0; i < 3; i++)
            push_flit(32'hA000_0000 + i, i == 2);
        chk("a_req_e0", 64'(request), 64'd0);
        step();
        chk("a_req_e1", 64'(request), 64'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("a_req_hold", 64'(request), 64'd1);
            chk("a_no_tx", 64'(tx_valid), 64'd0);
        end
        pulse_grant();
        chk("a_tx0_valid", 64'(tx_valid), 64'd1);
        chk("a_tx0_req", 64'(request), 64'd0);
        chk("a_tx0_last", 64'(tx_last), 64'd0);
        step();
        chk("a_tx1_last", 64'(tx_last), 64'd0);
        step();
        chk("a_tx2_last", 64'(tx_last), 64'd1);
        step();
        chk("a_done", 64'(done), 64'd1);
        chk("a_done_txv", 64'(tx_valid), 64'd0);
        step();
        chk("a_done_pulse", 64'(done), 64'd0);

        // Packets B (2 flits) and C (1 flit): one packet per grant
        push_flit(32'hB000_0000, 1'b0);
        push_flit(32'hB000_0001, 1'b1);
        push_flit(32'hC000_0000, 1'b1);
        send_pkt("b_send");
        step();
        chk("bc_idle_gap", 64'(request), 64'd0);
        step();
        chk("bc_rereq", 64'(request), 64'd1);
        send_pkt("c_send");
        for (int i = 0; i < 3; i++) step();
        chk("bc_no_req", 64'(request), 64'd0);
        chk("bc_pkt_count", 64'(dut.pkt_count), 64'd0);

        // Fill the FIFO with 16 single-flit packets, then offer one more
        for (int i = 0; i < 16; i++)
            push_flit(32'h1000_0000 + i, 1'b1);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        push_flit(32'hBAD0_0000, 1'b1);
        wait_req("full_req");
        pulse_grant();
        chk("full_ready_tx", 64'(in_ready), 64'd0);
        step();
        chk("full_ready_back", 64'(in_ready), 64'd1);
        chk("full_done", 64'(done), 64'd1);
        for (int i = 0; i < 15; i++)
            send_pkt("drain_send");
        step();
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
        chk("no_spurious", 64'(spurious_grant), 64'd0);

        // Grant in IDLE is ignored and sets the sticky flag
        step();
        pulse_grant();
        chk("spur_no_tx", 64'(tx_valid), 64'd0);
        chk("spur_set", 64'(spurious_grant), 64'd1);
        for (int i = 0; i < 3; i++) step();
        chk("spur_sticky", 64'(spurious_grant), 64'd1);
        chk("spur_idle", 64'(request), 64'd0);

        // Reset mid-XMIT discards the packet without a done
        for (int i = 0; i < 3; i++)
            push_flit(32'hD000_0000 + i, i == 2);
        wait_req("d_req");
        pulse_grant();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_txv", 64'(tx_valid), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_req", 64'(request), 64'd0);
        chk("mid_rst_data", 64'(tx_data), 64'd0);
        chk("mid_rst_spur", 64'(spurious_grant), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_count", 64'(dut.count), 64'd0);
        chk("mid_rst_sent2", 64'(sb_q.size()), 64'd1);
        sb_q.delete();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_rst_quiet", 64'({done, request, tx_valid}), 64'd0);
        end
        push_flit(32'hE000_0000, 1'b0);
        push_flit(32'hE000_0001, 1'b1);
        send_pkt("e_send");
        step();
        chk("e_empty", 64'(sb_q.size()), 64'd0);

`ifdef TX_CLIENT_STATS_EN
        do_reset();
        push_flit(32'hF000_0000, 1'b1);
        wait_req("f_req");
        for (int i = 0; i < 6; i++) step();
        pulse_grant();
        wait_done("f_done");
        push_flit(32'hF000_0001, 1'b1);
        send_pkt("g_send");
        step();
        chk("stat_sent", 64'(pkts_sent), 64'd2);
        chk("stat_wait", 64'(grant_wait_max), 64'd7);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
